regfl_wr_arb: RTL and testbench
===============================

# regfl_wr_arb

Round-robin write-port arbiter for the 4x8 register file (`regfl_4x8`). It lets four requesters share the file's single write port. Each request is a two-cycle transaction: a grant/write cycle followed by a recovery cycle. The arbiter sits between the requesters and the file's `wr_e`/`wr_addr`/`wr_data` inputs. The read port is not touched.

## Interface
- `NREQ`, 4, number of requesters (fixed; not to be overridden).
- `DW`, 8, data width; matches the register-file word.
- `AW`, 2, address width; matches the register-file depth of 4.
- `clk`  in  1  clock, rising-edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `req`  in  4  request per requester; held high with payload stable until the matching `gnt` is seen.
- `req_addr`  in  8  requester k address at bits [2k+1:2k].
- `req_data`  in  32  requester k data at bits [8k+7:8k].
- `lock`  in  4  burst lock per requester; present only with `REGFL_ARB_LOCK_EN`.
- `gnt`  out  4  registered one-hot grant, high for exactly one cycle.
- `wr_e`  out  1  registered write enable to the register file.
- `wr_addr`  out  2  registered write address.
- `wr_data`  out  8  registered write data.
- `busy`  out  1  high while the FSM is in WRITE.

## Operation
- FSM with two states: IDLE and WRITE.
- **IDLE**
  - If `req`==0, stay in IDLE. All outputs hold 0, except that `wr_addr`/`wr_data` keep their last values.
  - Otherwise pick winner w and go to WRITE.
  - On the same edge, register `gnt`=1<<w, `wr_e`=1, `wr_addr`=`req_addr[w]` and `wr_data`=`req_data[w]`, and set `ptr`=w.
- **WRITE**
  - Clear `gnt` and `wr_e` and go to IDLE unconditionally.
  - `req` is ignored in this state. The requester drops or replaces its request on this same edge.
- Round-robin selection:
  - `ptr` (2 bits) holds the index of the last winner.
  - Search order is ptr+1, ptr+2, ptr+3, ptr, all mod 4, with wrap-around 3→0.
  - The first requester asserting `req` wins.
- Only the winner's payload is sampled. Payload of losing requesters is don't-care.
- Write collisions cannot happen: there is exactly one `wr_e` pulse per grant.
- Reset values (asynchronous, while `rst_b`=0):
  - state IDLE, `ptr`=3 (so requester 0 has priority on the first arbitration).
  - `gnt`=0, `wr_e`=0, `wr_addr`=0, `wr_data`=0, `busy`=0.
  - Lock owner cleared.
- Reset asserted mid-transaction aborts it.
  - If reset asserts before the `wr_e` edge, the write is lost.
  - The requester must re-request after `rst_b` rises.

## Timing
- Latency:
  - `req` is sampled high at edge E1.
  - `gnt`/`wr_e`/`wr_addr`/`wr_data` are valid from E1 to E2.
  - The register file loads at E2.
  - The requester samples `gnt` at E2.
- Next arbitration happens at E3. Peak throughput is one write per 2 cycles.
- Worst-case wait with all four requesting and no lock: 8 cycles from `req` to `gnt`.
- Read-after-write: data is visible on `rd_data` of `regfl_4x8` from E2 onward.
- `busy` equals the registered state, so it is high from E1 to E2.

## Configuration
- Macro: `REGFL_ARB_LOCK_EN`.
- **Defined:**
  - The `lock` port exists.
  - Lock is captured from `lock[w]` at the grant edge into a lock-owner register.
  - At the next IDLE arbitration, if the owner still asserts `req`, it wins regardless of round-robin order, and `ptr` is unchanged.
  - Otherwise the lock is released and normal round-robin resumes.
  - A locked burst sustains one write per 2 cycles.
- **Undefined:**
  - No `lock` port and no lock-owner register.
  - Pure round-robin.

## Test plan
- **Reset:**
  - Assert `rst_b`=0 mid-WRITE → `gnt`=0, `wr_e`=0, `wr_addr`=0, `wr_data`=0 and `busy`=0 immediately.
  - After release, the first `req`=4'b1111 grants requester 0.
- **Single requester:**
  - Requester 2 writes addr 2, data 0x2E → one-cycle `gnt`=4'b0100 and `wr_e`=1.
  - `rd_addr`=2 reads 0x2E after E2.
  - There is no second `wr_e` pulse.
- **Full contention:**
  - `req`=4'b1111 held; each requester drops after its grant.
  - Grant sequence is 0,1,2,3, at 2-cycle spacing.
  - The file then holds the four supplied words: A2, 98, 2E, 55 at addresses 0..3.
- **Wrap-around:**
  - `ptr`=3 after granting 3, then `req`=4'b1001 → requester 0 wins.
  - The following arbitration grants 3.
- **Same-address race:**
  - Requesters 1 and 3 both target address 3, with data 0xFF and 0xC7, `ptr`=0.
  - Requester 1 is written first and requester 3 second; final reg3 = 0xC7.
- **Lock (macro defined):**
  - Requester 1 holds `lock`=1 and `req` for 3 writes while `req[0]` is high.
  - Grants are 1,1,1,0.
  - Without the macro, the same stimulus grants 1,0,1,0,1.

Source files
------------

// File: rtl/regfl_wr_arb.sv
// regfl_wr_arb -- round-robin arbiter for the single write port of regfl_4x8.
//
// Four requesters share one write port. Each grant is a two-cycle
// transaction: a grant/write cycle (state WRITE, wr_e high) followed by a
// recovery cycle back in IDLE, where the next arbitration happens.
//
// Optional feature: define REGFL_ARB_LOCK_EN to add the `lock` port and a
// lock-owner register that lets a requester hold the port for a burst.
//
// Ports:
//   clk       rising-edge clock
//   rst_b     asynchronous active-low reset
//   req       per-requester request, held with stable payload until gnt
//   req_addr  requester k address at [2k+1:2k]
//   req_data  requester k data at [8k+7:8k]
//   lock      per-requester burst lock (REGFL_ARB_LOCK_EN only)
//   gnt       registered one-hot grant, one cycle wide
//   wr_e      registered write enable to the register file
//   wr_addr   registered write address (holds last value when idle)
//   wr_data   registered write data (holds last value when idle)
//   busy      high while the FSM is in WRITE
module regfl_wr_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
`ifdef REGFL_ARB_LOCK_EN
    input  logic [NREQ-1:0]      lock,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic                 wr_e,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic                 busy
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   ptr, ptr_nx;
    logic [NREQ-1:0] gnt_nx;
    logic            wr_e_nx;
    logic [AW-1:0]   wr_addr_nx;
    logic [DW-1:0]   wr_data_nx;
    logic [AW-1:0]   rr_win;
    logic [AW-1:0]   win;
    logic [AW-1:0]   idx;
    logic            found;
    logic            lock_hit;

`ifdef REGFL_ARB_LOCK_EN
    logic            lock_vld, lock_vld_nx;
    logic [AW-1:0]   lock_own, lock_own_nx;
`endif

    // Round-robin search starting one past the last winner; i == NREQ
    // wraps back to ptr itself, so the last winner has lowest priority.
    always_comb begin
        rr_win = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = ptr + AW'(i);
            if (!found && req[idx]) begin
                rr_win = idx;
                found  = 1'b1;
            end
        end
    end

`ifdef REGFL_ARB_LOCK_EN
    // A locked owner that is still requesting overrides round-robin.
    assign lock_hit = lock_vld && req[lock_own];
    assign win      = lock_hit ? lock_own : rr_win;
`else
    assign lock_hit = 1'b0;
    assign win      = rr_win;
`endif

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        gnt_nx     = '0;
        wr_e_nx    = 1'b0;
        wr_addr_nx = wr_addr;
        wr_data_nx = wr_data;
`ifdef REGFL_ARB_LOCK_EN
        lock_vld_nx = lock_vld;
        lock_own_nx = lock_own;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nx   = WRITE;
                    gnt_nx     = NREQ'(1) << win;
                    wr_e_nx    = 1'b1;
                    wr_addr_nx = req_addr[int'(win)*AW +: AW];
                    wr_data_nx = req_data[int'(win)*DW +: DW];
                    // A lock-granted burst leaves the rotation where it was.
                    ptr_nx     = lock_hit ? ptr : win;
`ifdef REGFL_ARB_LOCK_EN
                    lock_vld_nx = lock[win];
                    lock_own_nx = win;
`endif
                end else begin
`ifdef REGFL_ARB_LOCK_EN
                    // Owner is not requesting: release the lock.
                    lock_vld_nx = 1'b0;
`endif
                end
            end
            WRITE: begin
                // Recovery: requests are ignored; requesters update payload
                // on this edge.
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= IDLE;
            ptr     <= AW'(NREQ - 1);   // requester 0 first after reset
            gnt     <= '0;
            wr_e    <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            gnt     <= gnt_nx;
            wr_e    <= wr_e_nx;
            wr_addr <= wr_addr_nx;
            wr_data <= wr_data_nx;
        end
    end

`ifdef REGFL_ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lock_vld <= 1'b0;
            lock_own <= '0;
        end else begin
            lock_vld <= lock_vld_nx;
            lock_own <= lock_own_nx;
        end
    end
`endif

    assign busy = (state == WRITE);

endmodule

// File: tb/tb_regfl_wr_arb.sv
module tb_regfl_wr_arb;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [3:0]  req;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        wr_e;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
`ifdef REGFL_ARB_LOCK_EN
    logic [3:0]  lock = 4'b0000;
`endif

    regfl_wr_arb dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
`ifdef REGFL_ARB_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .wr_e     (wr_e),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } job_t;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] addr;
        logic [7:0] data;
    } exp_t;

    job_t jq[4][$];
    exp_t exp_q[$];
    logic [7:0] mem [4];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = -1;
    bit mon_skip = 1'b0;
    bit spacing_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model loaded by the arbiter's write port.
    always @(posedge clk) if (wr_e) mem[wr_addr] <= wr_data;

    // Requester models: drop the granted job during the grant cycle and
    // present the next queued job (if any) for the following arbitration.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (gnt[k] === 1'b1 && jq[k].size() > 0) void'(jq[k].pop_front());
            if (jq[k].size() > 0) begin
                req[k]            = 1'b1;
                req_addr[2*k +: 2] = jq[k][0].addr;
                req_data[8*k +: 8] = jq[k][0].data;
            end else begin
                req[k] = 1'b0;
            end
        end
    end

    // Monitor: compare every write pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            checks++;
            if (busy !== wr_e || (wr_e !== 1'b1 && gnt !== 4'b0000)) begin
                errors++;
                $display("FAIL busy_gnt_idle: busy=%b wr_e=%b gnt=%b required busy==wr_e, gnt=0 when idle",
                         busy, wr_e, gnt);
            end
            if (wr_e === 1'b1 && !mon_skip) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_wr_e: gnt=%b addr=%0d data=%h required no write", gnt, wr_addr, wr_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({gnt, wr_addr, wr_data} !== e) begin
                        errors++;
                        $display("FAIL grant: gnt=%b addr=%0d data=%h required gnt=%b addr=%0d data=%h",
                                 gnt, wr_addr, wr_data, e.gnt, e.addr, e.data);
                    end
                    if (spacing_chk && last_cyc >= 0) begin
                        checks++;
                        if (cyc - last_cyc != 2) begin
                            errors++;
                            $display("FAIL spacing: %0d cycles required 2", cyc - last_cyc);
                        end
                    end
                    last_cyc = cyc;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, expv);
        end
    endtask

    task automatic job(input int k, input logic [1:0] a, input logic [7:0] d);
        jq[k].push_back('{addr: a, data: d});
    endtask

    task automatic expect_wr(input int k, input logic [1:0] a, input logic [7:0] d);
        exp_q.push_back('{gnt: 4'b0001 << k, addr: a, data: d});
    endtask

    function automatic int pending();
        return exp_q.size() + jq[0].size() + jq[1].size() + jq[2].size() + jq[3].size();
    endfunction

    // Wait for the scoreboard and requesters to drain, then idle a few
    // cycles so a spurious extra write pulse would reach the monitor.
    task automatic wait_done(input string name);
        int n = 0;
        while (pending() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL timeout_%s: %0d items outstanding required 0", name, pending());
            exp_q.delete();
            for (int k = 0; k < 4; k++) jq[k].delete();
        end
        #1;
    endtask

    initial begin
        int n;
        req      = 4'b0000;
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {gnt, wr_e, wr_addr, wr_data, busy}, '0);
        @(negedge clk);
        rst_b = 1'b1;

        // Reset mid-WRITE aborts the transaction.
        mon_skip = 1'b1;
        @(posedge clk);
        #1;
        job(0, 2'd1, 8'h11);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wr_e !== 1'b1 && n < 20);
        chk("midwrite_wr_e_seen", {31'd0, wr_e}, 32'd1);
        #2;
        rst_b = 1'b0;
        for (int k = 0; k < 4; k++) jq[k].delete();
        #1;
        chk("midwrite_reset_outputs", {gnt, wr_e, wr_addr, wr_data, busy}, '0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("aborted_write_lost", mem[1], 8'h00);
        mon_skip = 1'b0;

        // Full contention: first arbitration after reset grants 0.
        job(0, 2'd0, 8'hA2); job(1, 2'd1, 8'h98); job(2, 2'd2, 8'h2E); job(3, 2'd3, 8'h55);
        expect_wr(0, 2'd0, 8'hA2); expect_wr(1, 2'd1, 8'h98);
        expect_wr(2, 2'd2, 8'h2E); expect_wr(3, 2'd3, 8'h55);
        spacing_chk = 1'b1;
        last_cyc    = -1;
        wait_done("contention");
        spacing_chk = 1'b0;
        chk("contention_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'hA2982E55);

        // Single requester 2.
        job(2, 2'd2, 8'h2E);
        expect_wr(2, 2'd2, 8'h2E);
        wait_done("single");
        chk("single_mem2", mem[2], 8'h2E);

        // Wrap-around: grant 3 alone, then 0 and 3 together -> 0 then 3.
        job(3, 2'd0, 8'h33);
        expect_wr(3, 2'd0, 8'h33);
        wait_done("wrap_pre");
        job(0, 2'd1, 8'h01); job(3, 2'd2, 8'h03);
        expect_wr(0, 2'd1, 8'h01); expect_wr(3, 2'd2, 8'h03);
        wait_done("wrap");

        // Same-address race with ptr=0: 1 first, 3 second.
        job(0, 2'd0, 8'h5A);
        expect_wr(0, 2'd0, 8'h5A);
        wait_done("race_pre");
        job(1, 2'd3, 8'hFF); job(3, 2'd3, 8'hC7);
        expect_wr(1, 2'd3, 8'hFF); expect_wr(3, 2'd3, 8'hC7);
        wait_done("race");
        chk("race_mem3", mem[3], 8'hC7);

        // Burst by requester 1 alongside requester 0, ptr=0, no lock.
        job(0, 2'd0, 8'h00);
        expect_wr(0, 2'd0, 8'h00);
        wait_done("burst_pre");
        job(1, 2'd1, 8'hB1); job(1, 2'd1, 8'hB2); job(1, 2'd1, 8'hB3);
        job(0, 2'd0, 8'hA1); job(0, 2'd0, 8'hA7);
        expect_wr(1, 2'd1, 8'hB1); expect_wr(0, 2'd0, 8'hA1);
        expect_wr(1, 2'd1, 8'hB2); expect_wr(0, 2'd0, 8'hA7);
        expect_wr(1, 2'd1, 8'hB3);
        wait_done("burst");
        chk("burst_mem", {mem[0], mem[1]}, {16'd0, 8'hA7, 8'hB3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
